// File: rtl/delay_line_prog_if.sv
// Sample/control bundle for delay_line_prog. The master drives the line and
// the slave is the delay line itself.
interface delay_line_prog_if #(
    parameter int W     = 16,
    parameter int CH    = 3,
    parameter int D_MAX = 16
);
    localparam int DW = $clog2(D_MAX + 1);

    logic              en;
    logic [CH*W-1:0]   data_in;
    logic              valid_in;
    logic [DW-1:0]     delay_sel;
    logic              delay_ld;
    logic              flush;
    logic [CH*W-1:0]   data_out;
    logic              valid_out;
    logic [DW-1:0]     delay_cur;
    logic              filling;

    modport master (
        output en, data_in, valid_in, delay_sel, delay_ld, flush,
        input  data_out, valid_out, delay_cur, filling
    );
    modport slave (
        input  en, data_in, valid_in, delay_sel, delay_ld, flush,
        output data_out, valid_out, delay_cur, filling
    );
endinterface

// File: rtl/delay_line_prog.sv
// Multi-channel programmable delay line: one shift register per channel, a
// shared valid column, and a fill FSM that hides stale taps after a change.
module delay_line_prog_lane #(
    parameter int W     = 16,
    parameter int D_MAX = 16,
    parameter int AW    = $clog2(D_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [W-1:0]  d_i,
    input  logic [AW-1:0] tap_i,
    output logic [W-1:0]  q_o
);
    logic [D_MAX-1:0][W-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= {sr_q[D_MAX-2:0], d_i};
        end
    end

    assign q_o = sr_q[tap_i];
endmodule

module delay_line_prog #(
    parameter int W      = 16,
    parameter int CH     = 3,
    parameter int D_MAX  = 16,
    parameter int D_INIT = 16,
    parameter int DW     = $clog2(D_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    delay_line_prog_if.slave bus
);
    localparam int AW = $clog2(D_MAX);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [D_MAX-1:0]        vld_q;
    logic [DW-1:0]           delay_q, delay_d;
    logic [DW-1:0]           cnt_q, cnt_d;
    logic [0:0]              state_q, state_d;
    logic [DW-1:0]           sel_clamp;
    logic [AW-1:0]           tap;
    logic [CH-1:0][W-1:0]    lane_q;
    logic                    restart;

    assign restart = bus.delay_ld | bus.flush;
    assign tap     = AW'(delay_q - DW'(1));

    for (genvar c = 0; c < CH; c++) begin : g_lane
        delay_line_prog_lane #(.W(W), .D_MAX(D_MAX), .AW(AW)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (bus.en),
            .d_i   (bus.data_in[c*W +: W]),
            .tap_i (tap),
            .q_o   (lane_q[c])
        );
    end

    always_comb begin
        sel_clamp = bus.delay_sel;
        if (bus.delay_sel == '0)              sel_clamp = DW'(1);
        else if (bus.delay_sel > DW'(D_MAX))  sel_clamp = DW'(D_MAX);
    end

    // The restart edge itself counts as the first fill step when enabled, so a
    // new delay of 1 leaves FILL in the same edge.
    always_comb begin
        delay_d = bus.delay_ld ? sel_clamp : delay_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (restart) begin
            cnt_d   = bus.en ? DW'(1) : '0;
            state_d = (cnt_d == delay_d) ? S_RUN : S_FILL;
        end else if (state_q == S_FILL && bus.en) begin
            cnt_d   = cnt_q + DW'(1);
            state_d = (cnt_d == delay_q) ? S_RUN : S_FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            delay_q <= DW'(D_INIT);
            cnt_q   <= '0;
            state_q <= S_RUN;
        end else begin
            // Flush kills stored valids but the sample entering this edge survives.
            if (bus.flush)   vld_q <= bus.en ? {{(D_MAX-1){1'b0}}, bus.valid_in} : '0;
            else if (bus.en) vld_q <= {vld_q[D_MAX-2:0], bus.valid_in};
            delay_q <= delay_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign bus.data_out  = lane_q;
    assign bus.valid_out = (state_q == S_RUN) & vld_q[tap];
    assign bus.delay_cur = delay_q;
    assign bus.filling   = (state_q == S_FILL);
endmodule
